// File: rtl/usb_tx_pkt_framer.sv
`default_nettype none
// ============================================================================
// Module   : usb_tx_pkt_framer
// Purpose  : USB FS transmit framer: PID + payload LSB-first with inline CRC16.
//            Optional macro USB_TX_UNDERRUN_ABORT_EN: abort with a forced
//            bit-stuff error on payload underrun instead of stalling.
// Revision : 1.0 - initial release
// ============================================================================
module usb_tx_pkt_framer #(
   parameter int               WIDTH = 16,
   parameter logic [WIDTH-1:0] POLY  = 16'h8005,
   parameter logic [WIDTH-1:0] MATCH = 16'h800D
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       i_pkt_start,
   input  logic [3:0] i_pkt_pid,
   input  logic       i_pkt_crc_en,
   input  logic [7:0] i_pkt_data,
   input  logic       i_pkt_valid,
   input  logic       i_pkt_last,
   output logic       o_pkt_ready,
   input  logic       i_pkt_empty,
   input  logic       i_bit_ce,
   output logic       o_out_bit,
   output logic       o_out_valid,
   output logic       o_out_last,
   output logic       o_busy,
   output logic       o_underrun
);
   localparam int              c_CW        = $clog2(WIDTH + 1);
   localparam logic [c_CW-1:0] c_ONE       = c_CW'(1);
   localparam logic [c_CW-1:0] c_BYTE_BITS = c_CW'(8);
   localparam logic [c_CW-1:0] c_CRC_BITS  = c_CW'(WIDTH);
`ifdef USB_TX_UNDERRUN_ABORT_EN
   localparam logic [c_CW-1:0] c_ABORT_BITS = c_CW'(7);
`endif

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_PID   = 3'd1,
      S_DATA  = 3'd2,
      S_CRC   = 3'd3,
      S_WAIT  = 3'd4,
      S_ABORT = 3'd5
   } state_t;

   state_t            r_state, w_state_nxt;
   logic [7:0]        r_shreg, w_shreg_nxt;
   logic [c_CW-1:0]   r_cnt, w_cnt_nxt;
   logic [WIDTH-1:0]  r_crc, w_crc_nxt;
   logic [WIDTH-1:0]  r_crcsh, w_crcsh_nxt;
   logic              r_crc_en, w_crc_en_nxt;
   logic              r_empty, w_empty_nxt;
   logic              r_last, w_last_nxt;
   logic              w_need, w_ready, w_underrun;
   logic              w_bit, w_take, w_end, w_fb;
   logic [WIDTH-1:0]  w_crc_upd;

   assign w_bit = (r_state == S_CRC)   ? ~r_crcsh[WIDTH-1] :
                  (r_state == S_ABORT) ? 1'b1 :
                  (r_state == S_PID || r_state == S_DATA) ? r_shreg[0] : 1'b0;

   assign o_out_valid = (r_state == S_PID) || (r_state == S_DATA) ||
                        (r_state == S_CRC) || (r_state == S_ABORT);
   assign o_out_bit   = w_bit;
   assign o_busy      = (r_state != S_IDLE);
   assign w_take      = o_out_valid & i_bit_ce;
   assign w_end       = (r_cnt == c_ONE);
   assign o_out_last  = w_end && ((r_state == S_CRC) || (r_state == S_ABORT) ||
                                  ((r_state == S_PID) && !r_crc_en));
   // No byte is accepted and no underrun is flagged in a reset cycle.
   assign o_pkt_ready = w_ready & rst_n;
   assign o_underrun  = w_underrun & rst_n;

   // In CRC the register keeps running over the transmitted CRC bits, as a receiver would.
   assign w_fb      = r_crc[WIDTH-1] ^ w_bit;
   assign w_crc_upd = {r_crc[WIDTH-2:0], 1'b0} ^ (w_fb ? POLY : '0);

   always_comb begin
      w_state_nxt  = r_state;
      w_shreg_nxt  = r_shreg;
      w_cnt_nxt    = r_cnt;
      w_crc_nxt    = r_crc;
      w_crcsh_nxt  = r_crcsh;
      w_crc_en_nxt = r_crc_en;
      w_empty_nxt  = r_empty;
      w_last_nxt   = r_last;
      w_need       = 1'b0;
      w_ready      = 1'b0;
      w_underrun   = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (i_pkt_start) begin
               w_shreg_nxt  = {~i_pkt_pid, i_pkt_pid};
               w_cnt_nxt    = c_BYTE_BITS;
               w_crc_nxt    = '1;
               w_crc_en_nxt = i_pkt_crc_en;
               w_empty_nxt  = i_pkt_empty;
               w_last_nxt   = 1'b0;
               w_state_nxt  = S_PID;
            end
         end
         S_PID: begin
            if (w_take) begin
               w_shreg_nxt = {1'b0, r_shreg[7:1]};
               w_cnt_nxt   = r_cnt - c_ONE;
               if (w_end) begin
                  if (!r_crc_en) begin
                     w_state_nxt = S_IDLE;
                  end else if (r_empty) begin
                     w_state_nxt = S_CRC;
                     w_cnt_nxt   = c_CRC_BITS;
                     w_crcsh_nxt = r_crc;
                  end else begin
                     w_need = 1'b1;
                  end
               end
            end
         end
         S_DATA: begin
            if (w_take) begin
               w_crc_nxt   = w_crc_upd;
               w_shreg_nxt = {1'b0, r_shreg[7:1]};
               w_cnt_nxt   = r_cnt - c_ONE;
               if (w_end) begin
                  if (r_last) begin
                     w_state_nxt = S_CRC;
                     w_cnt_nxt   = c_CRC_BITS;
                     w_crcsh_nxt = w_crc_upd;
                  end else begin
                     w_need = 1'b1;
                  end
               end
            end
         end
         S_WAIT: w_need = 1'b1;
         S_CRC: begin
            if (w_take) begin
               w_crc_nxt   = w_crc_upd;
               w_crcsh_nxt = {r_crcsh[WIDTH-2:0], 1'b0};
               w_cnt_nxt   = r_cnt - c_ONE;
               if (w_end) w_state_nxt = S_IDLE;
            end
         end
         S_ABORT: begin
            if (w_take) begin
               w_cnt_nxt = r_cnt - c_ONE;
               if (w_end) w_state_nxt = S_IDLE;
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase

      // Byte reload keeps the bit stream gap-free when the source is ready.
      if (w_need) begin
         if (i_pkt_valid) begin
            w_ready     = 1'b1;
            w_shreg_nxt = i_pkt_data;
            w_cnt_nxt   = c_BYTE_BITS;
            w_last_nxt  = i_pkt_last;
            w_state_nxt = S_DATA;
         end else if (r_state != S_WAIT) begin
            w_underrun = 1'b1;
`ifdef USB_TX_UNDERRUN_ABORT_EN
            w_state_nxt = S_ABORT;
            w_cnt_nxt   = c_ABORT_BITS;
`else
            w_state_nxt = S_WAIT;
`endif
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_shreg  <= '0;
         r_cnt    <= '0;
         r_crc    <= '1;
         r_crcsh  <= '0;
         r_crc_en <= 1'b0;
         r_empty  <= 1'b0;
         r_last   <= 1'b0;
      end else begin
         r_shreg  <= w_shreg_nxt;
         r_cnt    <= w_cnt_nxt;
         r_crc    <= w_crc_nxt;
         r_crcsh  <= w_crcsh_nxt;
         r_crc_en <= w_crc_en_nxt;
         r_empty  <= w_empty_nxt;
         r_last   <= w_last_nxt;
      end
   end

   always_ff @(posedge clk) begin
      if (rst_n && (r_state == S_CRC) && w_take && w_end)
         assert (w_crc_upd == MATCH);
   end
endmodule
`default_nettype wire

// File: tb/tb_usb_tx_pkt_framer.sv
`default_nettype none
// tb_usb_tx_pkt_framer : directed self-checking bench for usb_tx_pkt_framer.
module tb_usb_tx_pkt_framer;
   logic       clk = 1'b0;
   logic       rst_n;
   logic       i_pkt_start, i_pkt_crc_en, i_pkt_valid, i_pkt_last, i_pkt_empty, i_bit_ce;
   logic [3:0] i_pkt_pid;
   logic [7:0] i_pkt_data;
   logic       o_pkt_ready, o_out_bit, o_out_valid, o_out_last, o_busy, o_underrun;

   always #5 clk = ~clk;

   usb_tx_pkt_framer dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .i_pkt_start  (i_pkt_start),
      .i_pkt_pid    (i_pkt_pid),
      .i_pkt_crc_en (i_pkt_crc_en),
      .i_pkt_data   (i_pkt_data),
      .i_pkt_valid  (i_pkt_valid),
      .i_pkt_last   (i_pkt_last),
      .o_pkt_ready  (o_pkt_ready),
      .i_pkt_empty  (i_pkt_empty),
      .i_bit_ce     (i_bit_ce),
      .o_out_bit    (o_out_bit),
      .o_out_valid  (o_out_valid),
      .o_out_last   (o_out_last),
      .o_busy       (o_busy),
      .o_underrun   (o_underrun)
   );

   int         n_total = 0;
   int         n_bad   = 0;
   logic [7:0] src[$];
   logic       bits[$];
   int         last_pos, n_last, n_ready, n_under, n_gap, consumed, cd, ce_mode, cyc_cnt;
   bit         hold_armed, released, seen_busy, went_idle;
   logic [6:0] tail;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic logic [7:0] byte_at(input int k);
      logic [7:0] b;
      for (int j = 0; j < 8; j++)
         b[j] = (8*k + j < bits.size()) ? bits[8*k + j] : 1'bx;
      return b;
   endfunction

   function automatic logic [15:0] rx_residual();
      logic [15:0] s;
      logic        fb;
      s = 16'hFFFF;
      for (int i = 8; i < bits.size(); i++) begin
         fb = s[15] ^ bits[i];
         s  = {s[14:0], 1'b0} ^ (fb ? 16'h8005 : 16'h0000);
      end
      return s;
   endfunction

   task automatic load_msg();
      src.delete();
      for (int i = 0; i < 9; i++) src.push_back(8'h31 + 8'(i));
   endtask

   task automatic drive_src();
      if (cd > 0) begin
         i_pkt_valid = 1'b0;
         cd--;
      end else begin
         i_pkt_valid = (src.size() > 0) && !(hold_armed && !released && consumed == 1);
      end
      i_pkt_data = (src.size() > 0) ? src[0] : 8'h00;
      i_pkt_last = (src.size() == 1);
      i_bit_ce   = (ce_mode == 0) ? 1'b1 : ((cyc_cnt % 3) != 0);
   endtask

   task automatic clear_cap();
      bits.delete();
      last_pos = -1; n_last = 0; n_ready = 0; n_under = 0; n_gap = 0;
      consumed = 0; cd = 0; released = 0; seen_busy = 0; went_idle = 0;
   endtask

   // One clock: observe at the falling edge, then drive just after the rising edge.
   task automatic cyc();
      @(negedge clk);
      if (o_out_valid && i_bit_ce) begin
         if (o_out_last) begin
            n_last++;
            last_pos = bits.size();
         end
         bits.push_back(o_out_bit);
      end
      if (o_pkt_ready) begin
         n_ready++;
         consumed++;
         if (src.size() > 0) src.delete(0);
      end
      if (o_underrun) begin
         n_under++;
         if (hold_armed && !released) begin
            released = 1;
            cd = 4;
         end
      end
      if (o_busy && !o_out_valid) n_gap++;
      if (seen_busy && !o_busy) went_idle = 1;
      if (o_busy) seen_busy = 1;
      @(posedge clk);
      #1;
      cyc_cnt++;
      drive_src();
   endtask

   task automatic send(input logic [3:0] pid, input logic crc_en, input logic empty, input int poke);
      clear_cap();
      drive_src();
      i_pkt_pid = pid; i_pkt_crc_en = crc_en; i_pkt_empty = empty; i_pkt_start = 1'b1;
      cyc();
      i_pkt_start = 1'b0;
      for (int k = 1; k < 600 && !went_idle; k++) begin
         i_pkt_start = (k == poke);
         if (k == poke) i_pkt_pid = ~pid;
         cyc();
      end
      i_pkt_start = 1'b0;
      check("pkt_end_seen", 32'(went_idle), 32'd1);
   endtask

   task automatic check_msg_frame(input string tag, input logic [7:0] pid_byte);
      check({tag, "_len"}, bits.size(), 96);
      check({tag, "_pid"}, byte_at(0), pid_byte);
      for (int i = 0; i < 9; i++)
         check($sformatf("%s_d%0d", tag, i), byte_at(1 + i), 8'h31 + 8'(i));
      check({tag, "_crc_lo"}, byte_at(10), 8'hC8);
      check({tag, "_crc_hi"}, byte_at(11), 8'hB4);
      check({tag, "_lastpos"}, last_pos, 95);
      check({tag, "_nlast"}, n_last, 1);
      check({tag, "_nready"}, n_ready, 9);
      check({tag, "_loopback"}, rx_residual(), 16'h800D);
   endtask

   initial begin
      rst_n = 1'b0; i_pkt_start = 1'b0; i_pkt_pid = 4'h0; i_pkt_crc_en = 1'b0;
      i_pkt_data = 8'h00; i_pkt_valid = 1'b0; i_pkt_last = 1'b0; i_pkt_empty = 1'b0;
      i_bit_ce = 1'b1; ce_mode = 0; hold_armed = 0; cd = 0; cyc_cnt = 0;
      clear_cap();
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(negedge clk);
      check("rst_ready", o_pkt_ready, 0);
      check("rst_bit",   o_out_bit,   0);
      check("rst_valid", o_out_valid, 0);
      check("rst_last",  o_out_last,  0);
      check("rst_busy",  o_busy,      0);
      check("rst_under", o_underrun,  0);
      @(posedge clk);
      #1;

      // ACK handshake: PID only
      send(4'h2, 1'b0, 1'b0, 0);
      check("ack_len",     bits.size(), 8);
      check("ack_pid",     byte_at(0), 8'hD2);
      check("ack_lastpos", last_pos, 7);
      check("ack_nlast",   n_last, 1);
      check("ack_nready",  n_ready, 0);
      check("ack_gap",     n_gap, 0);

      // Zero-length DATA0 with an intermittent bit_ce
      ce_mode = 1;
      send(4'h3, 1'b1, 1'b1, 0);
      ce_mode = 0;
      check("zl_len",     bits.size(), 24);
      check("zl_pid",     byte_at(0), 8'hC3);
      check("zl_crc_lo",  byte_at(1), 8'h00);
      check("zl_crc_hi",  byte_at(2), 8'h00);
      check("zl_lastpos", last_pos, 23);
      check("zl_nready",  n_ready, 0);

      // DATA1 "123456789" with a stray pkt_start mid-packet
      load_msg();
      send(4'hB, 1'b1, 1'b0, 30);
      check_msg_frame("crc", 8'h4B);
      check("crc_gap",   n_gap, 0);
      check("crc_under", n_under, 0);

      // Underrun before the second byte
      load_msg();
      hold_armed = 1;
      send(4'hB, 1'b1, 1'b0, 0);
      hold_armed = 0;
      check("ur_pulses", n_under, 1);
`ifdef USB_TX_UNDERRUN_ABORT_EN
      for (int i = 0; i < 7; i++) tail[i] = (16 + i < bits.size()) ? bits[16 + i] : 1'bx;
      check("ur_len",     bits.size(), 23);
      check("ur_pid",     byte_at(0), 8'h4B);
      check("ur_d0",      byte_at(1), 8'h31);
      check("ur_ones",    tail, 7'h7F);
      check("ur_lastpos", last_pos, 22);
      check("ur_nready",  n_ready, 1);
      src.delete();
`else
      check_msg_frame("ur", 8'h4B);
      check("ur_gap", n_gap, 5);
`endif

      // Reset in the middle of the payload, then a fresh packet
      load_msg();
      clear_cap();
      drive_src();
      i_pkt_pid = 4'hB; i_pkt_crc_en = 1'b1; i_pkt_empty = 1'b0; i_pkt_start = 1'b1;
      cyc();
      i_pkt_start = 1'b0;
      repeat (20) cyc();
      rst_n = 1'b0;
      cyc();
      rst_n = 1'b1;
      @(negedge clk);
      check("mid_rst_valid", o_out_valid, 0);
      check("mid_rst_busy",  o_busy, 0);
      check("mid_rst_nlast", n_last, 0);
      @(posedge clk);
      #1;
      load_msg();
      send(4'h3, 1'b1, 1'b0, 0);
      check_msg_frame("post", 8'hC3);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish, bad=%0d", n_bad);
      $fatal(1);
   end
endmodule
`default_nettype wire

// File: doc/usb_tx_pkt_framer.md
Name: usb_tx_pkt_framer

Overview:
- Transmit-side packet framer for the USB full-speed core.
- Takes a PID plus a byte stream through a valid/ready handshake and serialises it LSB-first to the bit-stuffer/NRZI stage.
- Computes CRC16 inline over the data bits and appends it after the last data byte; handshake packets are sent PID-only.
- Counterpart of the receive-side serial CRC checker: the bit ordering and complemented CRC output must match it, so a looped-back packet checks clean.

Parameters:
- WIDTH, 16, CRC register width.
- POLY, 16'h8005, CRC polynomial in non-reflected form, shifted MSB-first into the state.
- MATCH, 16'h800D, CRC residual expected by the receiver; used only by the optional self-check.

Ports:
- clk  in  1  core clock
- rst_n  in  1  reset
- pkt_start  in  1  one-cycle strobe; starts a packet when the block is idle
- pkt_pid  in  4  PID, sampled with pkt_start
- pkt_crc_en  in  1  1 = data packet (data bytes + CRC16); 0 = PID-only packet; sampled with pkt_start
- pkt_data  in  8  payload byte
- pkt_valid  in  1  pkt_data is valid
- pkt_last  in  1  current byte is the final payload byte
- pkt_ready  out  1  byte accepted this cycle
- pkt_empty  in  1  zero-length data packet; sampled with pkt_start
- bit_ce  in  1  downstream consumes out_bit this cycle
- out_bit  out  1  serial bit
- out_valid  out  1  out_bit is valid
- out_last  out  1  out_bit is the final bit of the packet (downstream emits EOP after it)
- busy  out  1  a packet is in progress
- underrun  out  1  one-cycle pulse: payload byte missing when needed

Behaviour:
- Single clock domain.
- Reset is synchronous and active-low: port rst_n, sampled on the rising edge of clk.
- Reset values: pkt_ready=0, out_bit=0, out_valid=0, out_last=0, busy=0, underrun=0, CRC state all ones, FSM in IDLE.
- FSM states: IDLE, PID, DATA, CRC.
- IDLE:
  - pkt_start loads the shift register with {~pid, pid}, sets bit count = 8 and busy=1, and moves to PID.
  - out_valid rises the following cycle.
  - pkt_start while busy is ignored.
- Serialisation:
  - out_bit = shreg[0]; out_valid=1 in PID, DATA and CRC.
  - On bit_ce with out_valid=1: shift right and decrement the bit count.
  - bit_ce while out_valid=0 is ignored.
- PID, on the 8th bit_ce:
  - pkt_crc_en=0: this bit carries out_last=1 and the FSM returns to IDLE.
  - pkt_empty=1: go to CRC.
  - Otherwise: go to DATA and require the first byte.
- Byte reload:
  - A byte is needed in the cycle the 8th bit of the current byte is consumed.
  - If pkt_valid=1 that cycle: pkt_ready=1 for that cycle, shreg loads pkt_data, bit count = 8. out_bit has no gap.
  - pkt_last captured with the byte: after that byte's 8th bit, go to CRC.
- CRC computation:
  - Each DATA bit consumed updates the state. Feedback = state[WIDTH-1] XOR bit; new state = {state[WIDTH-2:0],0} XOR (feedback ? POLY : 0).
  - CRC state is set to all ones at pkt_start.
- CRC state:
  - Transmitted CRC bit i = ~state[WIDTH-1-i], for i = 0..15, i=0 first. The CRC is frozen on CRC entry.
  - out_last=1 on bit 15; after its bit_ce, busy=0 and return to IDLE.
- Underrun (pkt_valid=0 when a byte is needed):
  - underrun pulses for one cycle.
  - Behaviour then depends on the optional feature.
- Reset mid-packet: the next cycle is IDLE, out_valid=0, and no out_last is issued.
- pkt_ready is never asserted outside DATA reload cycles, including the PID-to-DATA transition cycle, which counts as a reload.

Optional Feature:
- USB_TX_UNDERRUN_ABORT_EN defined: on underrun, out_valid is driven 1 with out_bit=1 for 7 consecutive bit_ce (a forced bit-stuff error), out_last=1 on the 7th, then IDLE. The CRC is not sent.
- Undefined: out_valid=0 while waiting. The FSM stalls until pkt_valid=1 and then continues normally.

Test Plan:
- ACK: pkt_start, pid=4'h2, crc_en=0 -> bits LSB-first of 0xD2, out_last on the 8th bit, busy falls afterwards, pkt_ready never 1.
- Zero-length DATA0: pid=4'h3, crc_en=1, empty=1 -> 0xC3 then 16 zero bits, out_last on bit 24.
- CRC check: DATA1 carrying ASCII "123456789" -> 0x4B, the 9 bytes, then CRC bytes 0xC8, 0xB4 LSB-first. Exactly 9 pkt_ready pulses; bits contiguous when bit_ce is held high.
- Loopback: the framed stream (excluding the PID) fed into the receive CRC checker -> residual equals MATCH after the last bit.
- Underrun: drop pkt_valid before byte 2 -> underrun pulse. With the macro: 7 ones, then out_last. Without it: out_valid=0 for 5 cycles, then correct resumption and the correct CRC.
- Reset mid-DATA: rst_n=0 for 1 cycle -> out_valid=0 and busy=0 next cycle. A new pkt_start then produces a correct packet with a fresh CRC.
